uc_seq: RTL

UC_SEQ -- requirements
Module: uc_seq

---
 rtl/uc_pkg.sv | 51 +++++
 rtl/uc_seq_if.sv | 29 ++
 rtl/uc_decode.sv | 37 +++
 rtl/uc_seq.sv | 76 +++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared types and encodings for the uc_seq micro-sequencer:
// FSM state enum, opcode field constants, ALU op codes and the control word.
package uc_pkg;

    typedef enum logic [1:0] {
        ST_HALTED = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2
    } state_t;

    // opcode[3:0] classes when opcode[3] = 1
    localparam logic [3:0] OPC_LI   = 4'b1000;
    localparam logic [3:0] OPC_JMP  = 4'b1001;

    // Full-width encodings
    localparam logic [5:0] OPC_NOP  = 6'b001111;
    localparam logic [5:0] OPC_HALT = 6'b111111;

    // Jump condition field opcode[5:4]
    localparam logic [1:0] JC_J     = 2'b00;
    localparam logic [1:0] JC_JZ    = 2'b01;
    localparam logic [1:0] JC_JNZ   = 2'b10;

    // ALU op codes; ALU instructions pass opcode[2:0] straight through,
    // ALU_IDLE is driven whenever no ALU instruction is executing.
    localparam logic [2:0] ALU_IDLE = 3'b000;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic [2:0] op;
        logic       pc_en;
        logic       flag_en;
        logic       illegal;
        logic       halt;
    } ctrl_t;

    // Control word presented while not executing (halted or in reset)
    localparam ctrl_t CTRL_HALTED = '{
        s_inc:   1'b1,
        s_inm:   1'b0,
        we3:     1'b0,
        op:      ALU_IDLE,
        pc_en:   1'b0,
        flag_en: 1'b0,
        illegal: 1'b0,
        halt:    1'b0
    };

endpackage

// File: rtl/uc_seq_if.sv
// Instruction/control bundle between the datapath side and uc_seq.
interface uc_seq_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic             zero;
    logic             run;
    logic             step;
    logic             halt_req;
    logic             s_inc;
    logic             s_inm;
    logic             we3;
    logic [2:0]       op;
    logic             pc_en;
    logic             flag_en;
    logic             halted;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        output opcode, zero, run, step, halt_req,
        input  s_inc, s_inm, we3, op, pc_en, flag_en, halted, illegal, retired
    );

    modport slave (
        input  opcode, zero, run, step, halt_req,
        output s_inc, s_inm, we3, op, pc_en, flag_en, halted, illegal, retired
    );
endinterface

// File: rtl/uc_decode.sv
// Pure combinational opcode/zero -> control word decode for an executing cycle.
module uc_decode
    import uc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       zero,
    output ctrl_t      ctrl
);

    // Decode one instruction; anything not matched is flagged illegal
    always_comb begin
        ctrl       = CTRL_HALTED;
        ctrl.pc_en = 1'b1;
        if (!opcode[3]) begin
            ctrl.op      = opcode[2:0];
            ctrl.we3     = 1'b1;
            ctrl.flag_en = 1'b1;
        end else if (opcode[3:0] == OPC_LI) begin
            ctrl.we3   = 1'b1;
            ctrl.s_inm = 1'b1;
        end else if (opcode[3:0] == OPC_JMP && opcode[5:4] != 2'b11) begin
            case (opcode[5:4])
                JC_J:    ctrl.s_inc = 1'b0;
                JC_JZ:   ctrl.s_inc = ~zero;
                default: ctrl.s_inc = zero;
            endcase
        end else if (opcode == OPC_NOP) begin
            ctrl.halt = 1'b0;
        end else if (opcode == OPC_HALT) begin
            ctrl.halt = 1'b1;
        end else begin
            ctrl.pc_en   = 1'b0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/uc_seq.sv
// uc_seq: HALTED/RUN/STEP micro-sequencer with zero-latency decode,
// sticky illegal-opcode flag and retired-instruction counter.
// Optional feature: define UC_STEP_EN to enable single-step execution;
// without it the step input is ignored and the STEP state is never entered.
module uc_seq
    import uc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic     clk,
    input  logic     reset,
    uc_seq_if.slave  bus
);

    state_t           state_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    ctrl_t            dec;
    ctrl_t            cw;
    logic             exec;

    uc_decode u_decode (
        .opcode (bus.opcode),
        .zero   (bus.zero),
        .ctrl   (dec)
    );

    // Reset forces the halted control word so an in-flight instruction cannot write
    assign exec = (state_q != ST_HALTED) && !reset;
    assign cw   = exec ? dec : CTRL_HALTED;

    assign bus.s_inc   = cw.s_inc;
    assign bus.s_inm   = cw.s_inm;
    assign bus.we3     = cw.we3;
    assign bus.op      = cw.op;
    assign bus.pc_en   = cw.pc_en;
    assign bus.flag_en = cw.flag_en;
    assign bus.halted  = !exec;
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;

    // FSM, sticky illegal flag and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_HALTED;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            case (state_q)
                ST_HALTED: begin
                    if (!illegal_q) begin
                        if (bus.run) begin
                            state_q <= ST_RUN;
`ifdef UC_STEP_EN
                        end else if (bus.step) begin
                            state_q <= ST_STEP;
`endif
                        end
                    end
                end
                default: begin
                    if (dec.illegal) begin
                        illegal_q <= 1'b1;
                        state_q   <= ST_HALTED;
                    end else begin
                        retired_q <= retired_q + CNT_W'(1);
                        if (dec.halt || bus.halt_req || state_q == ST_STEP) begin
                            state_q <= ST_HALTED;
                        end
                    end
                end
            endcase
        end
    end

endmodule
